// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : proc_pkg
//  Purpose  : Shared fetch FSM state type, instruction field bit positions
//             and opcode width used by the fetch unit and control decode.
//  Revision : 1.0  initial release
// ============================================================================
package proc_pkg;

  // Fetch unit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_t;

  // Opcode width shared with the ALU control decoder
  localparam int C_OP_W  = 3;
  localparam int C_REG_W = 3;
  localparam int C_IMM_W = 4;

  // Instruction field bit positions (16-bit instruction word)
  localparam int C_OP_MSB  = 15;
  localparam int C_OP_LSB  = 13;
  localparam int C_RD_MSB  = 12;
  localparam int C_RD_LSB  = 10;
  localparam int C_RS_MSB  = 9;
  localparam int C_RS_LSB  = 7;
  localparam int C_RT_MSB  = 6;
  localparam int C_RT_LSB  = 4;
  localparam int C_IMM_MSB = 3;
  localparam int C_IMM_LSB = 0;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Interface : instr_fetch_if
//  Purpose   : Instruction memory request/acknowledge bus between the fetch
//              unit (master) and instruction memory (slave).
//  Revision  : 1.0  initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch unit. Requests one word per FETCH, holds it in
//             ISSUE until the downstream stage accepts it, slices the fields
//             and steers the next fetch address (increment or branch target).
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_en,
  instr_fetch_if.master             imem,
  output logic [C_OP_W-1:0]         o_op,
  output logic [C_REG_W-1:0]        o_rd,
  output logic [C_REG_W-1:0]        o_rs,
  output logic [C_REG_W-1:0]        o_rt,
  output logic [C_IMM_W-1:0]        o_imm,
  output logic [ADDR_W-1:0]         o_pc,
  output logic                      o_instr_valid,
  input  wire logic                 i_instr_ready,
  input  wire logic                 i_br_taken,
  input  wire logic [ADDR_W-1:0]    i_br_target
);

  fetch_state_t        r_state;
  fetch_state_t        w_next_state;
  logic [ADDR_W-1:0]   r_fetch_addr;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                w_capture;
  logic                w_accept;

  // Capture happens only on an ack to our own outstanding request; an
  // accepted issue is the only point where a branch may redirect fetch.
  assign w_capture = (r_state == ST_FETCH) && imem.imem_ack;
  assign w_accept  = (r_state == ST_ISSUE) && i_instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_en)      w_next_state = ST_FETCH;
      ST_FETCH: if (w_capture) w_next_state = ST_ISSUE;
      ST_ISSUE: if (w_accept)  w_next_state = i_en ? ST_FETCH : ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  // Fetch address, PC and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_addr <= RESET_PC;
      r_pc         <= '0;
      r_instr      <= '0;
    end else begin
      if (w_capture) begin
        r_instr      <= imem.imem_rdata;
        r_pc         <= r_fetch_addr;
        r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
      end else if (w_accept && i_br_taken) begin
        r_fetch_addr <= i_br_target;
      end
    end
  end

  assign imem.imem_req  = (r_state == ST_FETCH);
  assign imem.imem_addr = r_fetch_addr;
  assign o_instr_valid  = (r_state == ST_ISSUE);
  assign o_pc           = r_pc;

  assign o_op  = r_instr[C_OP_MSB:C_OP_LSB];
  assign o_rd  = r_instr[C_RD_MSB:C_RD_LSB];
  assign o_rs  = r_instr[C_RS_MSB:C_RS_LSB];
  assign o_rt  = r_instr[C_RT_MSB:C_RT_LSB];
  assign o_imm = r_instr[C_IMM_MSB:C_IMM_LSB];

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch: per-cycle vector table plus
//             hand-written delayed-ack and stall sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;
  import proc_pkg::*;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int          NVEC    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_en;
  logic                i_instr_ready;
  logic                i_br_taken;
  logic [ADDR_W-1:0]   i_br_target;
  logic [C_OP_W-1:0]   o_op;
  logic [C_REG_W-1:0]  o_rd, o_rs, o_rt;
  logic [C_IMM_W-1:0]  o_imm;
  logic [ADDR_W-1:0]   o_pc;
  logic                o_instr_valid;

  int checks   = 0;
  int failures = 0;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .imem          (bus),
    .o_op          (o_op),
    .o_rd          (o_rd),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_imm         (o_imm),
    .o_pc          (o_pc),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .i_br_taken    (i_br_taken),
    .i_br_target   (i_br_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, ack;
    logic [15:0] rdata;
    logic        ready, br;
    logic [7:0]  tgt;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [15:0] e_ins;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic r, input logic e, input logic a,
                              input logic [15:0] d, input logic rd,
                              input logic b, input logic [7:0] t,
                              input logic xq, input logic [7:0] xa,
                              input logic xv, input logic [7:0] xp,
                              input logic [15:0] xi);
    vec_t v;
    v.rst = r; v.en = e; v.ack = a; v.rdata = d; v.ready = rd; v.br = b;
    v.tgt = t; v.e_req = xq; v.e_addr = xa; v.e_valid = xv; v.e_pc = xp;
    v.e_ins = xi;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic a,
                       input logic [15:0] d, input logic rd, input logic b,
                       input logic [7:0] t);
    rst = r; i_en = e; bus.imem_ack = a; bus.imem_rdata = d;
    i_instr_ready = rd; i_br_taken = b; i_br_target = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] w_fields;
  assign w_fields = {o_op, o_rd, o_rs, o_rt, o_imm};

  initial begin
    logic [7:0]  hold_addr;
    logic [15:0] hold_fields;
    logic [7:0]  hold_pc;
    bit          seen;

    //          rst en ack rdata    rdy br tgt     req addr  vld pc     instr
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00, 16'h0000);
    tbl[1]  = mk(0, 1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h00, 0, 8'h00, 16'h0000);
    tbl[2]  = mk(0, 1, 1, 16'h4A53, 0, 0, 8'h00,  0, 8'h01, 1, 8'h00, 16'h4A53);
    tbl[3]  = mk(0, 1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h01, 0, 8'h00, 16'h4A53);
    tbl[4]  = mk(0, 1, 1, 16'h1234, 0, 0, 8'h00,  0, 8'h02, 1, 8'h01, 16'h1234);
    tbl[5]  = mk(0, 1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h02, 0, 8'h01, 16'h1234);
    tbl[6]  = mk(0, 1, 1, 16'hBEEF, 0, 0, 8'h00,  0, 8'h03, 1, 8'h02, 16'hBEEF);
    tbl[7]  = mk(0, 1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h03, 0, 8'h02, 16'hBEEF);
    tbl[8]  = mk(0, 1, 1, 16'h0F0F, 0, 0, 8'h00,  0, 8'h04, 1, 8'h03, 16'h0F0F);
    // stall in ISSUE with stray acks that must be ignored
    tbl[9]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 8'h00,  0, 8'h04, 1, 8'h03, 16'h0F0F);
    tbl[10] = mk(0, 1, 1, 16'hFFFF, 0, 0, 8'h00,  0, 8'h04, 1, 8'h03, 16'h0F0F);
    tbl[11] = mk(0, 1, 1, 16'hFFFF, 0, 0, 8'h00,  0, 8'h04, 1, 8'h03, 16'h0F0F);
    // taken branch on accept, then branch in FETCH ignored
    tbl[12] = mk(0, 1, 0, 16'h0000, 1, 1, 8'h40,  1, 8'h40, 0, 8'h03, 16'h0F0F);
    tbl[13] = mk(0, 1, 0, 16'h0000, 1, 1, 8'h80,  1, 8'h40, 0, 8'h03, 16'h0F0F);
    tbl[14] = mk(0, 1, 1, 16'h2222, 0, 1, 8'h80,  0, 8'h41, 1, 8'h40, 16'h2222);
    // EN low parks in IDLE; acks in IDLE ignored
    tbl[15] = mk(0, 0, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h41, 0, 8'h40, 16'h2222);
    tbl[16] = mk(0, 0, 1, 16'hFFFF, 0, 0, 8'h00,  0, 8'h41, 0, 8'h40, 16'h2222);
    // EN drop mid-FETCH completes the fetch and issue
    tbl[17] = mk(0, 1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h41, 0, 8'h40, 16'h2222);
    tbl[18] = mk(0, 0, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h41, 0, 8'h40, 16'h2222);
    tbl[19] = mk(0, 0, 1, 16'h3333, 0, 0, 8'h00,  0, 8'h42, 1, 8'h41, 16'h3333);
    tbl[20] = mk(0, 0, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h42, 0, 8'h41, 16'h3333);
    // branch to 0xFF then wrap
    tbl[21] = mk(0, 1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h42, 0, 8'h41, 16'h3333);
    tbl[22] = mk(0, 1, 1, 16'h5555, 0, 0, 8'h00,  0, 8'h43, 1, 8'h42, 16'h5555);
    tbl[23] = mk(0, 1, 0, 16'h0000, 1, 1, 8'hFF,  1, 8'hFF, 0, 8'h42, 16'h5555);
    tbl[24] = mk(0, 1, 1, 16'h6666, 0, 0, 8'h00,  0, 8'h00, 1, 8'hFF, 16'h6666);
    tbl[25] = mk(0, 1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h00, 0, 8'hFF, 16'h6666);
    tbl[26] = mk(0, 1, 1, 16'h7777, 0, 0, 8'h00,  0, 8'h01, 1, 8'h00, 16'h7777);
    tbl[27] = mk(0, 1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h01, 0, 8'h00, 16'h7777);
    // reset mid-FETCH with coincident ack
    tbl[28] = mk(1, 1, 1, 16'h9999, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00, 16'h0000);
    tbl[29] = mk(0, 1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h00, 0, 8'h00, 16'h0000);
    tbl[30] = mk(0, 1, 1, 16'h1111, 0, 0, 8'h00,  0, 8'h01, 1, 8'h00, 16'h1111);
    // reset mid-ISSUE with ready and branch
    tbl[31] = mk(1, 1, 0, 16'h0000, 1, 1, 8'h55,  0, 8'h00, 0, 8'h00, 16'h0000);

    drive(1, 0, 0, 16'h0, 0, 0, 8'h0);
    step();

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].ack, tbl[i].rdata, tbl[i].ready,
            tbl[i].br, tbl[i].tgt);
      step();
      chk($sformatf("v%0d.req", i),   32'(bus.imem_req),  32'(tbl[i].e_req));
      chk($sformatf("v%0d.addr", i),  32'(bus.imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d.valid", i), 32'(o_instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d.pc", i),    32'(o_pc),          32'(tbl[i].e_pc));
      chk($sformatf("v%0d.fields", i), 32'(w_fields),     32'(tbl[i].e_ins));
    end

    // explicit field decode of 0x4A53 from a fresh fetch
    drive(1, 0, 0, 16'h0, 0, 0, 8'h0); step();
    drive(0, 1, 0, 16'h0, 0, 0, 8'h0); step();
    drive(0, 1, 1, 16'h4A53, 0, 0, 8'h0); step();
    chk("dec.op",  32'(o_op),  32'(3'b010));
    chk("dec.rd",  32'(o_rd),  32'(3'b010));
    chk("dec.rs",  32'(o_rs),  32'(3'b100));
    chk("dec.rt",  32'(o_rt),  32'(3'b101));
    chk("dec.imm", 32'(o_imm), 32'(4'h3));

    // delayed ack: request and address stay stable while waiting
    drive(0, 1, 0, 16'h0, 1, 0, 8'h0); step();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.imem_req) seen = 1'b1;
      else step();
    end
    chk("wait.req_seen", 32'(seen), 32'd1);
    hold_addr = bus.imem_addr;
    drive(0, 1, 0, 16'h0, 0, 0, 8'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("slow.req",  32'(bus.imem_req),  32'd1);
      chk("slow.addr", 32'(bus.imem_addr), 32'(hold_addr));
    end
    drive(0, 1, 1, 16'hC3A5, 0, 0, 8'h0); step();
    chk("slow.valid", 32'(o_instr_valid), 32'd1);
    chk("slow.pc",    32'(o_pc),          32'(hold_addr));
    chk("slow.ins",   32'(w_fields),      32'h0000C3A5);

    // stall with READY low: everything held, no new request
    hold_fields = w_fields; hold_pc = o_pc;
    drive(0, 1, 0, 16'h0, 0, 0, 8'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall.valid",  32'(o_instr_valid), 32'd1);
      chk("stall.req",    32'(bus.imem_req),  32'd0);
      chk("stall.fields", 32'(w_fields),      32'(hold_fields));
      chk("stall.pc",     32'(o_pc),          32'(hold_pc));
    end
    drive(0, 1, 0, 16'h0, 1, 0, 8'h0); step();
    chk("release.req",  32'(bus.imem_req),  32'd1);
    chk("release.addr", 32'(bus.imem_addr), 32'(hold_addr + 8'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
